// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Produces forwarding selects, load-use stalls, branch flushes and a
// drain sequence for instructions that write the PC. Also keeps saturating
// stall/flush event counters.
module hazard_controller #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset_asynchronous,
  input  logic [3:0]    RA1D,
  input  logic [3:0]    RA2D,
  input  logic [3:0]    RA1E,
  input  logic [3:0]    RA2E,
  input  logic [3:0]    WA3E,
  input  logic [3:0]    WA3M,
  input  logic [3:0]    WA3W,
  input  logic          RegWriteE,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic          MemtoRegE,
  input  logic          PCSrcD,
  input  logic          BranchTakenE,
  input  logic          ClearCounters,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          StallF,
  output logic          StallD,
  output logic          FlushD,
  output logic          FlushE,
  output logic [CW-1:0] StallCount,
  output logic [CW-1:0] FlushCount
);

  // state | meaning
  // RUN   | normal issue; load-use stalls and branch flushes handled here
  // DRAIN | PC-writing instruction travels E -> M -> W; fetch is held
  //       | until its W cycle and Decode is flushed throughout
  typedef enum logic {RUN, DRAIN} state_t;

  state_t     state;
  logic [1:0] drain_cnt;
  logic       ldr_stall;
  logic       pcsrc_trig;

  // Forwarding selects: Memory stage wins over Writeback; R15 is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RA1E == WA3M) && (RA1E != 4'd15))
      ForwardAE = 2'b10;
    else if (RegWriteW && (RA1E == WA3W) && (RA1E != 4'd15))
      ForwardAE = 2'b01;
    if (RegWriteM && (RA2E == WA3M) && (RA2E != 4'd15))
      ForwardBE = 2'b10;
    else if (RegWriteW && (RA2E == WA3W) && (RA2E != 4'd15))
      ForwardBE = 2'b01;
  end

  // Stall/flush controls, combinational from inputs and current state.
  always_comb begin
    ldr_stall  = 1'b0;
    pcsrc_trig = 1'b0;
    StallF     = 1'b0;
    StallD     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    if (state == RUN) begin
      ldr_stall  = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
      // A taken branch squashes the Decode instruction, so its PC write is moot.
      pcsrc_trig = PCSrcD & ~BranchTakenE;
      StallF     = ldr_stall | pcsrc_trig;
      StallD     = ldr_stall;
      FlushD     = pcsrc_trig | BranchTakenE;
      FlushE     = ldr_stall | BranchTakenE;
    end else begin
      // Fetch is released in the W cycle so the new PC is picked up next edge.
      StallF = (drain_cnt != 2'd1);
      FlushD = 1'b1;
      FlushE = BranchTakenE;
    end
  end

  // Drain sequencer: three cycles after a PC-writing instruction leaves Decode.
  always_ff @(posedge clk or posedge reset_asynchronous) begin
    if (reset_asynchronous) begin
      state     <= RUN;
      drain_cnt <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (pcsrc_trig) begin
            state     <= DRAIN;
            drain_cnt <= 2'd3;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - 2'd1;
          if (drain_cnt == 2'd1)
            state <= RUN;
        end
        default: begin
          state     <= RUN;
          drain_cnt <= 2'd0;
        end
      endcase
    end
  end

  // Saturating event counters; a clear request beats any increment.
  always_ff @(posedge clk or posedge reset_asynchronous) begin
    if (reset_asynchronous) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else if (ClearCounters) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (StallF && (StallCount != '1))
        StallCount <= StallCount + CW'(1);
      if (FlushE && (FlushCount != '1))
        FlushCount <= FlushCount + CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: a driver applies one stimulus per
// cycle and queues the reference model's expected outputs; a monitor pops
// and compares them later in the same cycle.
module tb_hazard_controller;

  localparam int CW = 16;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic rwe, rwm, rww, mte, pcs, bte, clr;
  } stim_t;

  typedef struct {
    logic [1:0] fa, fb;
    logic sf, sd, fd, fe;
    int sc, fc;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcD, BranchTakenE, ClearCounters;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, FlushD, FlushE;
  logic [CW-1:0] StallCount, FlushCount;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // reference model state: counts and the cycle a PC write left Decode
  int cyc = 0;
  int pc_cyc = -100;
  int m_sc = 0;
  int m_fc = 0;

  hazard_controller #(.CW(CW)) dut (
    .clk(clk), .reset_asynchronous(rst),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .BranchTakenE(BranchTakenE),
    .ClearCounters(ClearCounters),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s.ra1d = 0; s.ra2d = 0; s.ra1e = 0; s.ra2e = 0;
    s.wa3e = 0; s.wa3m = 0; s.wa3w = 0;
    s.rwe = 0; s.rwm = 0; s.rww = 0; s.mte = 0; s.pcs = 0; s.bte = 0; s.clr = 0;
    return s;
  endfunction

  function automatic logic [3:0] rreg();
    int v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 4'd15 : 4'(v);
  endfunction

  // Which producer holds the newest value of register ra (R15 is the PC).
  function automatic logic [1:0] fwd(logic [3:0] ra, stim_t s);
    if (ra == 4'd15) return 2'b00;
    if (s.rwm && ra == s.wa3m) return 2'b10;
    if (s.rww && ra == s.wa3w) return 2'b01;
    return 2'b00;
  endfunction

  task automatic apply(stim_t s);
    RA1D = s.ra1d; RA2D = s.ra2d; RA1E = s.ra1e; RA2E = s.ra2e;
    WA3E = s.wa3e; WA3M = s.wa3m; WA3W = s.wa3w;
    RegWriteE = s.rwe; RegWriteM = s.rwm; RegWriteW = s.rww;
    MemtoRegE = s.mte; PCSrcD = s.pcs; BranchTakenE = s.bte; ClearCounters = s.clr;
  endtask

  // One clock cycle of stimulus; do_rst pulses reset between the edges.
  task automatic cycle(stim_t s, bit do_rst, string nm);
    exp_t e;
    int d;
    bit drain, ldr, trig;
    @(negedge clk);
    if (!do_rst) rst = 1'b0;
    apply(s);
    #1;
    if (do_rst) begin
      rst = 1'b1;
      m_sc = 0; m_fc = 0; pc_cyc = -100;
    end
    #1;
    d = cyc - pc_cyc;
    drain = (d >= 1) && (d <= 3);
    ldr = 0; trig = 0;
    e.name = nm;
    e.fa = fwd(s.ra1e, s);
    e.fb = fwd(s.ra2e, s);
    if (drain) begin
      e.sf = (d < 3); e.sd = 0; e.fd = 1; e.fe = s.bte;
    end else begin
      ldr = s.mte && s.rwe && (s.wa3e == s.ra1d || s.wa3e == s.ra2d);
      trig = s.pcs && !s.bte;
      e.sf = ldr || trig; e.sd = ldr; e.fd = trig || s.bte; e.fe = ldr || s.bte;
    end
    e.sc = m_sc; e.fc = m_fc;
    exp_q.push_back(e);
    if (!do_rst) begin
      if (trig) pc_cyc = cyc;
      if (s.clr) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if (e.sf) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
        if (e.fe) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
      end
    end
    cyc++;
  endtask

  task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0h required=%0h at %0t", nm, fld, act, req, $time);
    end
  endtask

  // Monitor: compare queued expectations with the DUT mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.name, "ForwardAE", 32'(ForwardAE), 32'(e.fa));
      chk(e.name, "ForwardBE", 32'(ForwardBE), 32'(e.fb));
      chk(e.name, "StallF", 32'(StallF), 32'(e.sf));
      chk(e.name, "StallD", 32'(StallD), 32'(e.sd));
      chk(e.name, "FlushD", 32'(FlushD), 32'(e.fd));
      chk(e.name, "FlushE", 32'(FlushE), 32'(e.fe));
      chk(e.name, "StallCount", 32'(StallCount), 32'(e.sc));
      chk(e.name, "FlushCount", 32'(FlushCount), 32'(e.fc));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    apply(idle());
    cycle(idle(), 1'b1, "reset");
    cycle(idle(), 1'b0, "post_reset");

    // forwarding priority
    s = idle(); s.ra1e = 3; s.wa3m = 3; s.rwm = 1; s.wa3w = 3; s.rww = 1; s.ra2e = 3;
    cycle(s, 1'b0, "fwd_m_wins");
    s.rwm = 0;
    cycle(s, 1'b0, "fwd_w");
    s.rwm = 1; s.ra1e = 15; s.wa3m = 15; s.wa3w = 7; s.ra2e = 7;
    cycle(s, 1'b0, "fwd_r15");

    // load-use
    s = idle(); s.mte = 1; s.rwe = 1; s.wa3e = 5; s.ra2d = 5; s.ra1d = 2;
    cycle(s, 1'b0, "load_use");
    cycle(idle(), 1'b0, "load_use_count");

    // PC write drain
    s = idle(); s.pcs = 1;
    cycle(s, 1'b0, "pc_d");
    cycle(idle(), 1'b0, "pc_e");
    cycle(idle(), 1'b0, "pc_m");
    cycle(idle(), 1'b0, "pc_w");
    cycle(idle(), 1'b0, "pc_run");

    // PC write squashed by a taken branch
    s = idle(); s.pcs = 1; s.bte = 1;
    cycle(s, 1'b0, "squash");
    cycle(idle(), 1'b0, "squash_run");

    // load-use and branch together
    s = idle(); s.mte = 1; s.rwe = 1; s.wa3e = 9; s.ra1d = 9; s.bte = 1;
    cycle(s, 1'b0, "ldr_branch");

    // reset during the second drain cycle
    s = idle(); s.pcs = 1;
    cycle(s, 1'b0, "rst_pc_d");
    cycle(idle(), 1'b0, "rst_pc_e");
    cycle(idle(), 1'b1, "rst_mid_drain");
    cycle(idle(), 1'b0, "rst_after");

    // saturation then clear
    s = idle(); s.mte = 1; s.rwe = 1; s.wa3e = 5; s.ra2d = 5;
    for (int i = 0; i < (1 << CW) + 5; i++) cycle(s, 1'b0, "saturate");
    s.clr = 1;
    cycle(s, 1'b0, "clear_with_stall");
    cycle(idle(), 1'b0, "after_clear");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s.ra1d = rreg(); s.ra2d = rreg(); s.ra1e = rreg(); s.ra2e = rreg();
      s.wa3e = rreg(); s.wa3m = rreg(); s.wa3w = rreg();
      s.rwe = 1'($urandom_range(0, 1)); s.rwm = 1'($urandom_range(0, 1));
      s.rww = 1'($urandom_range(0, 1)); s.mte = 1'($urandom_range(0, 1));
      s.pcs = ($urandom_range(0, 7) == 0); s.bte = ($urandom_range(0, 7) == 0);
      s.clr = ($urandom_range(0, 63) == 0);
      cycle(s, ($urandom_range(0, 499) == 0), "random");
    end
    cycle(idle(), 1'b0, "final");

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0 entries left", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
